uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ requesters. Each requester has a valid/ready byte interface.
- Grants are round-robin. The block latches the granted byte, pulses the transmitter start, waits for the transmitter done pulse, then enforces a programmable inter-frame gap before the next grant.
- Sits between the host-side message sources and the UART TX datapath; it is the TX-side counterpart of the receiver FSM.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per frame (parity generated by transmitter).
- GAP_CYCLES, 16, clk cycles of idle enforced after tx_done (0 = no gap).
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with TX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*DBIT  requester i data at bits [i*DBIT +: DBIT]
- req_ready  out  NREQ  one-hot accept; a transfer occurs when valid&ready
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  DBIT  byte to transmitter, held stable from start until done
- tx_done  in  1  one-cycle pulse from transmitter at end of stop bit
- grant_id  out  $clog2(NREQ)  index of requester owning the current frame
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort (TX_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Gap and watchdog counters cleared.
- Reset mid-frame: the in-flight frame is dropped with no retry. A requester that was already accepted is not re-served for that byte.
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - Search req_valid starting at last+1, wrapping modulo NREQ; the first set bit wins.
  - req_ready is combinational: one-hot on the winner, only in IDLE, and only if any valid.
  - On transfer: tx_data<=req_data[winner], grant_id<=winner, last<=winner, go to LAUNCH.
  - No valid: stay in IDLE, req_ready=0.
- LAUNCH:
  - tx_start=1 for exactly this one cycle (Moore). Next cycle goes to WAIT.
  - Latency: request accept at cycle t gives tx_start at t+1.
  - tx_done is ignored in LAUNCH.
- WAIT:
  - tx_start=0; tx_data and grant_id held.
  - On tx_done: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Counter counts 0..GAP_CYCLES-1; returns to IDLE on the cycle after it reaches GAP_CYCLES-1. The gap occupies exactly GAP_CYCLES cycles.
  - req_valid is ignored during the gap.
- Requester rules:
  - Hold req_data stable while req_valid=1 and not yet accepted.
  - Dropping valid before acceptance is legal; that requester is simply skipped.
- Fairness: with all NREQ valid continuously, grants cycle 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 frames.
- Simultaneous events:
  - A valid arriving in the same cycle the FSM re-enters IDLE is not accepted until the following cycle, because the IDLE decision uses the registered state.
  - tx_done while in IDLE or GAP is ignored.
- busy is a registered decode of state.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done: pulse timeout_err for one cycle and go to GAP. The frame is abandoned; last keeps the aborted requester.
  - A tx_done arriving in the same cycle as the timeout takes precedence, and no error is raised.
- Undefined: no watchdog logic; timeout_err is constant 0. WAIT is left only on tx_done.

Test Plan:
- Reset, then req_valid=4'b0001 with byte 8'hA5 → req_ready=0001 same cycle, tx_start pulse next cycle, tx_data=A5, grant_id=0, busy=1. After tx_done, busy stays 1 for 16 cycles, then 0.
- All four valid continuously with bytes 11,22,33,44, tx_done returned 10 cycles after each start → tx_data sequence 11,22,33,44,11; grant_id 0,1,2,3,0.
- After grant to requester 2, valid=4'b0101 → next grant is 0 (wrap from 3). After that, valid=0101 again → next grant is 2.
- tx_done pulsed during LAUNCH and again during GAP → ignored, no state change. A second tx_done in WAIT completes the frame.
- reset_n asserted during WAIT → all outputs 0 immediately. After release, requester 0 has priority again; no stale tx_start.
- TX_TIMEOUT_EN, TIMEOUT_CYCLES=64, tx_done never returned → timeout_err pulses exactly 64 cycles after WAIT entry, then GAP, then IDLE. Without the macro, the block stays in WAIT indefinitely.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ valid/ready byte sources.
// Optional watchdog on the transmitter done pulse: define TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned DBIT           = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_data,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

  state_t        state;
  state_t        state_next;
  state_t        after_frame;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic          found;
  logic          accept;
  logic [GW-1:0] gap_cnt;
  logic          wd_expire;

  // First valid requester after the previous winner, wrapping modulo NREQ.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(last) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign accept      = (state == IDLE) && found;
  assign req_ready   = (accept && reset_n) ? (NREQ'(1) << winner) : '0;
  assign tx_start    = (state == LAUNCH);
  assign after_frame = (GAP_CYCLES > 0) ? GAP : IDLE;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (found) state_next = LAUNCH;
      LAUNCH: state_next = WAIT;
      WAIT:   if (tx_done || wd_expire) state_next = after_frame;
      GAP:    if (gap_cnt == GAP_LAST) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      last     <= IW'(NREQ - 1);
      tx_data  <= '0;
      grant_id <= '0;
      gap_cnt  <= '0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      gap_cnt <= (state == GAP && state_next == GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        tx_data  <= req_data[winner*DBIT +: DBIT];
        grant_id <= winner;
        last     <= winner;
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WW-1:0] wd_cnt;

  assign wd_expire = (state == WAIT) && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  // Counter is zero whenever WAIT is not being held, so it starts clean on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= (state == WAIT && state_next == WAIT) ? wd_cnt + 1'b1 : '0;
      timeout_err <= wd_expire && !tx_done;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences, randomized frames.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int GAP  = 16;
`ifdef TX_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DBIT-1:0]    req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    tx_start;
  logic [DBIT-1:0]         tx_data;
  logic                    tx_done;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;
  logic                    timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = NREQ - 1;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .DBIT(DBIT),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_byte;
    int          wait_cyc;
    bit          noisy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: scan from the requester after the last winner.
  function automatic int rr(input int last, input logic [3:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; tx_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_last = NREQ - 1;
  endtask

  // One complete frame starting from IDLE at a falling edge.
  task automatic run_frame(input logic [3:0] mask, input logic [31:0] data, input int exp_id,
                           input logic [7:0] exp_byte, input int wait_cyc, input bit noisy,
                           input bit hold);
    req_valid = mask; req_data = data; #1;
    check("accept_ready", 32'(req_ready), 32'd1 << exp_id);
    check("idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("launch_start", 32'(tx_start), 1);
    check("launch_data", 32'(tx_data), 32'(exp_byte));
    check("launch_grant", 32'(grant_id), exp_id);
    check("launch_busy", 32'(busy), 1);
    req_valid = hold ? mask : 4'($urandom); tx_done = noisy; #1;
    check("launch_ready", 32'(req_ready), 0);
    @(negedge clk);
    tx_done = 1'b0;
    for (int c = 0; c < wait_cyc; c++) begin
      req_valid = hold ? mask : 4'($urandom); #1;
      check("wait_start", 32'(tx_start), 0);
      check("wait_data", 32'(tx_data), 32'(exp_byte));
      check("wait_grant", 32'(grant_id), exp_id);
      check("wait_busy", 32'(busy), 1);
      check("wait_ready", 32'(req_ready), 0);
      check("wait_timeout", 32'(timeout_err), 0);
      @(negedge clk);
    end
    tx_done = 1'b1;
    @(negedge clk);
    for (int g = 0; g < GAP; g++) begin
      req_valid = hold ? mask : 4'($urandom);
      tx_done = noisy && (g == 3 || g == GAP - 1); #1;
      check("gap_busy", 32'(busy), 1);
      check("gap_ready", 32'(req_ready), 0);
      check("gap_start", 32'(tx_start), 0);
      @(negedge clk);
    end
    tx_done = 1'b0; req_valid = '0; #1;
    check("end_busy", 32'(busy), 0);
    check("end_ready", 32'(req_ready), 0);
    model_last = exp_id;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5, 5, 1'b0};
    vecs[1] = '{4'b1111, 32'h44332211, 1, 8'h22, 3, 1'b1};
    vecs[2] = '{4'b1111, 32'h44332211, 2, 8'h33, 1, 1'b0};
    vecs[3] = '{4'b0101, 32'h44332211, 0, 8'h11, 2, 1'b0};
    vecs[4] = '{4'b0101, 32'h44332211, 2, 8'h33, 0, 1'b1};
    vecs[5] = '{4'b1000, 32'h44332211, 3, 8'h44, 4, 1'b0};
    vecs[6] = '{4'b1010, 32'h44332211, 1, 8'h22, 2, 1'b0};
    vecs[7] = '{4'b0110, 32'h44332211, 2, 8'h33, 1, 1'b1};
    vecs[8] = '{4'b0011, 32'h44332211, 0, 8'h11, 6, 1'b0};
    vecs[9] = '{4'b1111, 32'h44332211, 1, 8'h22, 2, 1'b0};

    // Reset state, with all requesters asserting valid.
    reset_n = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211; tx_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_start", 32'(tx_start), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    @(negedge clk);
    @(negedge clk);
    req_valid = '0; reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_start", 32'(tx_start), 0);

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].mask, vecs[i].data, vecs[i].exp_id, vecs[i].exp_byte,
                vecs[i].wait_cyc, vecs[i].noisy, 1'b0);

    // All four valid continuously, done 10 cycles after each start.
    do_reset();
    run_frame(4'b1111, 32'h44332211, 0, 8'h11, 9, 1'b0, 1'b1);
    run_frame(4'b1111, 32'h44332211, 1, 8'h22, 9, 1'b0, 1'b1);
    run_frame(4'b1111, 32'h44332211, 2, 8'h33, 9, 1'b0, 1'b1);
    run_frame(4'b1111, 32'h44332211, 3, 8'h44, 9, 1'b0, 1'b1);
    run_frame(4'b1111, 32'h44332211, 0, 8'h11, 9, 1'b0, 1'b1);

    // Reset asserted while waiting for tx_done.
    req_valid = 4'b0100; #1;
    check("rw_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("rw_start", 32'(tx_start), 1);
    @(negedge clk);
    @(negedge clk);
    check("rw_busy", 32'(busy), 1);
    reset_n = 1'b0; #1;
    check("rw_rst_ready", 32'(req_ready), 0);
    check("rw_rst_start", 32'(tx_start), 0);
    check("rw_rst_data", 32'(tx_data), 0);
    check("rw_rst_grant", 32'(grant_id), 0);
    check("rw_rst_busy", 32'(busy), 0);
    check("rw_rst_timeout", 32'(timeout_err), 0);
    @(negedge clk);
    req_valid = '0; reset_n = 1'b1;
    model_last = NREQ - 1;
    @(negedge clk);
    check("rw_no_stale_start", 32'(tx_start), 0);
    check("rw_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("rw_no_stale_start2", 32'(tx_start), 0);
    run_frame(4'b1111, 32'h44332211, 0, 8'h11, 3, 1'b0, 1'b0);

    // Transmitter never answers.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h44332211; #1;
    check("to_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("to_start", 32'(tx_start), 1);
    req_valid = '0;
    @(negedge clk);
`ifdef TX_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      check("to_wait_err", 32'(timeout_err), 0);
      check("to_wait_busy", 32'(busy), 1);
      @(negedge clk);
    end
    check("to_pulse", 32'(timeout_err), 1);
    check("to_pulse_busy", 32'(busy), 1);
    @(negedge clk);
    check("to_pulse_end", 32'(timeout_err), 0);
    for (int g = 1; g < GAP; g++) begin
      check("to_gap_busy", 32'(busy), 1);
      @(negedge clk);
    end
    check("to_idle_busy", 32'(busy), 0);
`else
    for (int k = 0; k < 200; k++) begin
      check("nto_wait_busy", 32'(busy), 1);
      check("nto_wait_err", 32'(timeout_err), 0);
      @(negedge clk);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      check("nto_gap_busy", 32'(busy), 1);
      @(negedge clk);
    end
    check("nto_idle_busy", 32'(busy), 0);
`endif
    model_last = 0;
    run_frame(4'b1111, 32'h44332211, 1, 8'h22, 2, 1'b0, 1'b0);

    // Randomized frames against the round-robin rule.
    for (int f = 0; f < 40; f++) begin
      logic [3:0]  m;
      logic [31:0] d;
      int          id;
      m = 4'($urandom);
      d = $urandom;
      if (m == 4'b0000) begin
        req_valid = '0; #1;
        check("none_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("none_busy", 32'(busy), 0);
      end else begin
        id = rr(model_last, m);
        run_frame(m, d, id, d[id*8 +: 8], $urandom_range(0, 12), 1'($urandom), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
